pulse_stretcher: RTL

- Output-side counterpart of the button debouncer: it takes single-cycle event pulses from game logic (hit, shot, life lost) and drives a clean physical level (LED, buzzer enable).
- Each event becomes one output pulse with a guaranteed minimum high time and a minimum low gap.
- Events that arrive while a pulse or gap is in progress are queued in a saturating counter and replayed later.
- Timing is derived from the 36 MHz system clock through an internal microsecond prescaler.

---
 rtl/pulse_stretcher.sv | 110 +++++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// Turns single-cycle event pulses into clean output pulses with a guaranteed
// minimum high time and low gap, queuing events that arrive while busy.
module pulse_stretcher #(
    parameter int CLKS_PER_US = 36,
    parameter int HIGH_US     = 1000,
    parameter int LOW_US      = 1000,
    parameter int PEND_W      = 3
) (
    input  logic              clk_36MHz,
    input  logic              reset,
    input  logic              enable,
    input  logic              trigger,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int PS_W   = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int MAX_US = (HIGH_US > LOW_US) ? HIGH_US : LOW_US;
    localparam int US_W   = $clog2(MAX_US + 1);

    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(CLKS_PER_US - 1);
    localparam logic [US_W-1:0]   HIGH_LAST = US_W'(HIGH_US - 1);
    localparam logic [US_W-1:0]   LOW_LAST  = US_W'(LOW_US - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [PS_W-1:0]   presc;
    logic [US_W-1:0]   us_cnt;
    logic [PEND_W-1:0] next_pending;
    logic              next_overflow;
    logic              high_done;
    logic              low_done;

    assign high_done = (state == HIGH) && (presc == PS_LAST) && (us_cnt == HIGH_LAST);
    assign low_done  = (state == LOW)  && (presc == PS_LAST) && (us_cnt == LOW_LAST);

    // On the final gap cycle a new trigger and a queued event cancel out:
    // one is consumed by the pulse that starts next, the other stays queued.
    always_comb begin
        next_state    = state;
        next_pending  = pending;
        next_overflow = overflow;
        case (state)
            IDLE: begin
                if (trigger) next_state = HIGH;
            end
            HIGH: begin
                if (trigger) begin
                    if (pending == PEND_MAX) next_overflow = 1'b1;
                    else                     next_pending  = pending + PEND_W'(1);
                end
                if (high_done) next_state = LOW;
            end
            LOW: begin
                if (low_done) begin
                    next_state = (pending != '0 || trigger) ? HIGH : IDLE;
                    if (!trigger && pending != '0) next_pending = pending - PEND_W'(1);
                end else if (trigger) begin
                    if (pending == PEND_MAX) next_overflow = 1'b1;
                    else                     next_pending  = pending + PEND_W'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            out      <= 1'b0;
            busy     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else if (enable) begin
            state    <= next_state;
            out      <= (next_state == HIGH);
            busy     <= (next_state != IDLE);
            pending  <= next_pending;
            overflow <= next_overflow;
        end
    end

    // Timing counters restart on every state entry and idle at zero.
    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            presc  <= '0;
            us_cnt <= '0;
        end else if (enable) begin
            if (next_state != state || state == IDLE) begin
                presc  <= '0;
                us_cnt <= '0;
            end else if (presc == PS_LAST) begin
                presc  <= '0;
                us_cnt <= us_cnt + US_W'(1);
            end else begin
                presc <= presc + PS_W'(1);
            end
        end
    end

endmodule
